pool_scheduler: RTL

Scheduler stage 1: reads the packed per-slot instruction vectors the pool presents (slot 0 = main core, slots 1..COP_NUMS = coprocessors), picks one issuable slot per cycle in strict slot order and registers it onto a single issue port. Tracks destination registers of issued instructions in a 32-entry scoreboard to block RAW/WAW hazards. Back-pressures the pool through `HAZARD_STALL` until every valid slot of the current pool word has issued.

---
 rtl/pool_scheduler_pkg.sv | 26 ++
 rtl/pool_scoreboard.sv | 41 ++++
 rtl/pool_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pool_scheduler_pkg.sv
// Shared constants for the pool scheduler: slot field widths, NOP encoding
// and the empty-slot marker the pool uses for unused slots.
package pool_scheduler_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned OPC_W  = 17;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [OPC_W-1:0]  NOP_OPCODE   = {7'b0010011, 3'b000, 7'b0000000};
  localparam logic [XLEN_W-1:0] NOP_RINST    = 32'h0000_0013;
  localparam logic [OPC_W-1:0]  EMPTY_OPCODE = 17'h1_C000;

  // One-hot register mask; x0 never participates in hazard tracking.
  function automatic logic [NREGS-1:0] reg_mask(input logic [REG_W-1:0] idx);
    logic [NREGS-1:0] m;
    m = 32'd0;
    if (idx != 5'd0) begin
      m[idx] = 1'b1;
    end else begin
      m = 32'd0;
    end
    return m;
  endfunction

endpackage

// File: rtl/pool_scoreboard.sv
// 32-entry busy scoreboard: issue sets, writeback clears (set wins on a
// same-register collision), flush empties it. eff_busy already has WB applied.
module pool_scoreboard
  import pool_scheduler_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  output logic [NREGS-1:0] busy,
  output logic [NREGS-1:0] eff_busy
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;

  // Masks for this cycle's set and clear requests.
  always_comb begin
    set_mask_s = set_en ? reg_mask(set_idx) : 32'd0;
    clr_mask_s = clr_en ? reg_mask(clr_idx) : 32'd0;
  end

  assign eff_busy = busy_r & ~clr_mask_s;
  assign busy     = busy_r;

  // Busy vector update.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_r <= 32'd0;
    end else if (flush) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= eff_busy | set_mask_s;
    end
  end

endmodule

// File: rtl/pool_scheduler.sv
// Scheduler stage 1: in-order pick of one issuable pool slot per cycle onto a
// registered issue port, with scoreboard-based RAW/WAW blocking.
module pool_scheduler
  import pool_scheduler_pkg::*;
#(
  parameter  int unsigned COP_NUMS = 32'd1,
  parameter  int unsigned PNUMS    = COP_NUMS + 32'd1,
  localparam int unsigned ID_W     = (PNUMS > 32'd1) ? $clog2(PNUMS) : 32'd1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic                    STALL,
  input  logic                    MMU_WAIT,
  input  logic [XLEN_W*PNUMS-1:0] POOL_PC,
  input  logic [OPC_W*PNUMS-1:0]  POOL_OPCODE,
  input  logic [REG_W*PNUMS-1:0]  POOL_RD,
  input  logic [REG_W*PNUMS-1:0]  POOL_RS1,
  input  logic [REG_W*PNUMS-1:0]  POOL_RS2,
  input  logic [XLEN_W*PNUMS-1:0] POOL_RINST,
  input  logic                    WB_VALID,
  input  logic [REG_W-1:0]        WB_RD,
  output logic                    ISSUE_VALID,
  output logic [ID_W-1:0]         ISSUE_ID,
  output logic [XLEN_W-1:0]       ISSUE_PC,
  output logic [OPC_W-1:0]        ISSUE_OPCODE,
  output logic [REG_W-1:0]        ISSUE_RD,
  output logic [REG_W-1:0]        ISSUE_RS1,
  output logic [REG_W-1:0]        ISSUE_RS2,
  output logic [XLEN_W-1:0]       ISSUE_RINST,
  output logic                    HAZARD_STALL
);

  logic [PNUMS-1:0]  done_r;
  logic [PNUMS-1:0]  pending_s;
  logic [PNUMS-1:0]  cand_onehot_s;
  logic              cand_found_s;
  logic [ID_W-1:0]   cand_id_s;
  logic [XLEN_W-1:0] cand_pc_s;
  logic [OPC_W-1:0]  cand_opc_s;
  logic [REG_W-1:0]  cand_rd_s;
  logic [REG_W-1:0]  cand_rs1_s;
  logic [REG_W-1:0]  cand_rs2_s;
  logic [XLEN_W-1:0] cand_rinst_s;
  logic              blocked_s;
  logic              others_pending_s;
  logic              issue_s;
  logic [NREGS-1:0]  busy_s;
  logic [NREGS-1:0]  eff_busy_s;

  logic              issue_valid_r;
  logic [ID_W-1:0]   issue_id_r;
  logic [XLEN_W-1:0] issue_pc_r;
  logic [OPC_W-1:0]  issue_opc_r;
  logic [REG_W-1:0]  issue_rd_r;
  logic [REG_W-1:0]  issue_rs1_r;
  logic [REG_W-1:0]  issue_rs2_r;
  logic [XLEN_W-1:0] issue_rinst_r;

  // Priority encoder: lowest-index pending slot is the only candidate.
  always_comb begin
    pending_s     = {PNUMS{1'b0}};
    cand_onehot_s = {PNUMS{1'b0}};
    cand_found_s  = 1'b0;
    cand_id_s     = {ID_W{1'b0}};
    cand_pc_s     = 32'd0;
    cand_opc_s    = NOP_OPCODE;
    cand_rd_s     = 5'd0;
    cand_rs1_s    = 5'd0;
    cand_rs2_s    = 5'd0;
    cand_rinst_s  = NOP_RINST;
    for (int i = 0; i < int'(PNUMS); i++) begin
      pending_s[i] = (POOL_OPCODE[i*OPC_W +: OPC_W] != EMPTY_OPCODE) && !done_r[i];
      if (pending_s[i] && !cand_found_s) begin
        cand_found_s     = 1'b1;
        cand_onehot_s[i] = 1'b1;
        cand_id_s        = ID_W'(i);
        cand_pc_s        = POOL_PC[i*XLEN_W +: XLEN_W];
        cand_opc_s       = POOL_OPCODE[i*OPC_W +: OPC_W];
        cand_rd_s        = POOL_RD[i*REG_W +: REG_W];
        cand_rs1_s       = POOL_RS1[i*REG_W +: REG_W];
        cand_rs2_s       = POOL_RS2[i*REG_W +: REG_W];
        cand_rinst_s     = POOL_RINST[i*XLEN_W +: XLEN_W];
      end else begin
        cand_found_s = cand_found_s;
      end
    end
  end

  // Hazard check, issue decision and pool back-pressure.
  always_comb begin
    blocked_s        = cand_found_s &&
                       (eff_busy_s[cand_rs1_s] || eff_busy_s[cand_rs2_s] || eff_busy_s[cand_rd_s]);
    others_pending_s = |(pending_s & ~cand_onehot_s);
    issue_s          = !FLUSH && !STALL && !MMU_WAIT && cand_found_s && !blocked_s;
    HAZARD_STALL     = !FLUSH && cand_found_s && (others_pending_s || blocked_s);
  end

  pool_scoreboard u_sb (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (FLUSH),
    .set_en   (issue_s),
    .set_idx  (cand_rd_s),
    .clr_en   (WB_VALID),
    .clr_idx  (WB_RD),
    .busy     (busy_s),
    .eff_busy (eff_busy_s)
  );

  // Issue register and per-slot done tracking; the word retires with its last slot.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      issue_valid_r <= 1'b0;
      issue_id_r    <= {ID_W{1'b0}};
      issue_pc_r    <= 32'd0;
      issue_opc_r   <= NOP_OPCODE;
      issue_rd_r    <= 5'd0;
      issue_rs1_r   <= 5'd0;
      issue_rs2_r   <= 5'd0;
      issue_rinst_r <= NOP_RINST;
      done_r        <= {PNUMS{1'b0}};
    end else if (FLUSH || (!STALL && !MMU_WAIT && !issue_s)) begin
      issue_valid_r <= 1'b0;
      issue_id_r    <= {ID_W{1'b0}};
      issue_pc_r    <= 32'd0;
      issue_opc_r   <= NOP_OPCODE;
      issue_rd_r    <= 5'd0;
      issue_rs1_r   <= 5'd0;
      issue_rs2_r   <= 5'd0;
      issue_rinst_r <= NOP_RINST;
      done_r        <= FLUSH ? {PNUMS{1'b0}} : done_r;
    end else if (issue_s) begin
      issue_valid_r <= 1'b1;
      issue_id_r    <= cand_id_s;
      issue_pc_r    <= cand_pc_s;
      issue_opc_r   <= cand_opc_s;
      issue_rd_r    <= cand_rd_s;
      issue_rs1_r   <= cand_rs1_s;
      issue_rs2_r   <= cand_rs2_s;
      issue_rinst_r <= cand_rinst_s;
      done_r        <= others_pending_s ? (done_r | cand_onehot_s) : {PNUMS{1'b0}};
    end else begin
      done_r        <= done_r;
    end
  end

  assign ISSUE_VALID  = issue_valid_r;
  assign ISSUE_ID     = issue_id_r;
  assign ISSUE_PC     = issue_pc_r;
  assign ISSUE_OPCODE = issue_opc_r;
  assign ISSUE_RD     = issue_rd_r;
  assign ISSUE_RS1    = issue_rs1_r;
  assign ISSUE_RS2    = issue_rs2_r;
  assign ISSUE_RINST  = issue_rinst_r;

endmodule
